// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator: turns one-at-a-time cmd/rsp requests into AXI4-Lite reads/writes, one outstanding.
// Latency: accept-to-rsp_valid is 3 cycles minimum, +1 per responder wait cycle; 5-cycle peak issue rate.
// Backpressure: cmd_ready low while busy; rsp_* held until rsp_ready; watchdog only flags, never aborts.
module axi_lite_cmd_master #(
  parameter int STALL_LIMIT = 1024
) (
  input  logic        M_AXI_ACLK,
  input  logic        M_AXI_ARESETN,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        stall_flag,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WRESP, S_RADDR, S_RDATA, S_RSP
  } state_t;

  localparam logic [15:0] LIMIT = 16'(STALL_LIMIT);

  state_t      state_q, state_d;
  logic        awvalid_d, wvalid_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic [31:0] addr_q;
  logic        cmd_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire, rsp_fire;
  logic        wd_active;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign aw_fire  = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_fire   = M_AXI_WVALID && M_AXI_WREADY;
  assign b_fire   = M_AXI_BVALID && M_AXI_BREADY;
  assign ar_fire  = M_AXI_ARVALID && M_AXI_ARREADY;
  assign r_fire   = M_AXI_RVALID && M_AXI_RREADY;
  assign rsp_fire = rsp_valid && rsp_ready;

  // The same latched address serves both channels; only the matching valid is ever raised.
  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;

  assign wd_active = (state_q == S_WR) || (state_q == S_WRESP) ||
                     (state_q == S_RADDR) || (state_q == S_RDATA);

  // Next-state and next AW/W valids; each write valid drops independently on its own handshake.
  always_comb begin
    state_d   = state_q;
    awvalid_d = M_AXI_AWVALID;
    wvalid_d  = M_AXI_WVALID;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          state_d   = cmd_write ? S_WR : S_RADDR;
          awvalid_d = cmd_write;
          wvalid_d  = cmd_write;
        end
      end
      S_WR: begin
        if (aw_fire) awvalid_d = 1'b0;
        if (w_fire)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = S_WRESP;
      end
      S_WRESP: if (b_fire)   state_d = S_RSP;
      S_RADDR: if (ar_fire)  state_d = S_RDATA;
      S_RDATA: if (r_fire)   state_d = S_RSP;
      S_RSP:   if (rsp_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Watchdog count: restarts on any state change, advances only while waiting on the responder.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_d != state_q)
      wd_cnt_d = '0;
    else if (wd_active && (wd_cnt_q != 16'hFFFF))
      wd_cnt_d = wd_cnt_q + 16'd1;
  end

  // State, registered handshake outputs, watchdog and flag.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q       <= S_IDLE;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      wd_cnt_q      <= '0;
      stall_flag    <= 1'b0;
    end else begin
      state_q       <= state_d;
      // Re-armed one cycle after returning to IDLE, so accept-to-accept is at least 5 cycles.
      cmd_ready     <= (state_q == S_IDLE) && !cmd_fire;
      rsp_valid     <= (state_d == S_RSP);
      M_AXI_AWVALID <= awvalid_d;
      M_AXI_WVALID  <= wvalid_d;
      M_AXI_BREADY  <= (state_d == S_WRESP);
      M_AXI_ARVALID <= (state_d == S_RADDR);
      M_AXI_RREADY  <= (state_d == S_RDATA);
      wd_cnt_q      <= wd_cnt_d;
      if (wd_cnt_d >= LIMIT) stall_flag <= 1'b1;
    end
  end

  // Command and response data registers.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      addr_q      <= '0;
      M_AXI_WDATA <= '0;
      M_AXI_WSTRB <= '0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
    end else begin
      if ((state_q == S_IDLE) && cmd_fire) begin
        addr_q      <= cmd_addr;
        M_AXI_WDATA <= cmd_wdata;
        M_AXI_WSTRB <= cmd_wstrb;
        rsp_write   <= cmd_write;
      end
      if ((state_q == S_WRESP) && b_fire) begin
        rsp_resp  <= M_AXI_BRESP;
        rsp_rdata <= '0;
        rsp_write <= 1'b1;
      end
      if ((state_q == S_RDATA) && r_fire) begin
        rsp_resp  <= M_AXI_RRESP;
        rsp_rdata <= M_AXI_RDATA;
        rsp_write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: directed scenarios plus randomized transactions against a timing model.
// Model: per transaction, expected cycle windows for every valid/ready from the responder wait counts.
// Responder: tb-driven ready/valid pulses in chosen cycles relative to command accept (edge 0).
module tb_axi_lite_cmd_master;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        stall_flag;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int n_chk  = 0;
  int n_pass = 0;

  axi_lite_cmd_master #(.STALL_LIMIT(8)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .stall_flag(stall_flag),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Drive one command and play the responder. wa = AW/AR wait, wb = W wait, rw = B/R wait,
  // hold = cycles rsp_ready stays low. Checks every cycle until cmd_ready returns.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] strb, input int wa, input int wb, input int rw,
                         input int hold, input logic [1:0] resp, input logic [31:0] rd);
    int done, first, hs, k;
    logic [31:0] exp_rd;
    k = 0;
    while (!cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_ready_before_accept", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = strb;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_write = 1'($urandom);
    cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
    // Last address/data handshake cycle; response arrives rw cycles after the earliest slot.
    done   = wr ? 1 + ((wa > wb) ? wa : wb) : 1 + wa;
    first  = done + 2 + rw;
    hs     = first + hold;
    exp_rd = wr ? 32'h0 : rd;
    for (int c = 1; c <= hs + 2; c++) begin
      @(negedge clk);
      awready   = wr && (c == 1 + wa);
      wready    = wr && (c == 1 + wb);
      bvalid    = wr && (c == first - 1);
      bresp     = resp;
      arready   = !wr && (c == 1 + wa);
      rvalid    = !wr && (c == first - 1);
      rresp     = resp;
      rdata     = rd;
      rsp_ready = (c == hs);
      chk($sformatf("awvalid c%0d", c), awvalid, wr && (c <= 1 + wa));
      chk($sformatf("wvalid c%0d", c), wvalid, wr && (c <= 1 + wb));
      chk($sformatf("arvalid c%0d", c), arvalid, !wr && (c <= 1 + wa));
      chk($sformatf("bready c%0d", c), bready, wr && (c > done) && (c < first));
      chk($sformatf("rready c%0d", c), rready, !wr && (c > done) && (c < first));
      chk($sformatf("rsp_valid c%0d", c), rsp_valid, (c >= first) && (c <= hs));
      chk($sformatf("cmd_ready c%0d", c), cmd_ready, c >= hs + 2);
      if (wr && c <= 1 + wa) chk($sformatf("awaddr c%0d", c), awaddr, addr);
      if (wr && c <= 1 + wb) begin
        chk($sformatf("wdata c%0d", c), wdata, wd);
        chk($sformatf("wstrb c%0d", c), wstrb, strb);
      end
      if (!wr && c <= 1 + wa) chk($sformatf("araddr c%0d", c), araddr, addr);
      if (c >= first && c <= hs) begin
        chk($sformatf("rsp_write c%0d", c), rsp_write, wr);
        chk($sformatf("rsp_rdata c%0d", c), rsp_rdata, exp_rd);
        chk($sformatf("rsp_resp c%0d", c), rsp_resp, resp);
      end
    end
    chk("stall_flag_quiet", stall_flag, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rresp = 0; rdata = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst cmd_ready", cmd_ready, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst awvalid", awvalid, 0);
    chk("rst arvalid", arvalid, 0);
    chk("rst stall_flag", stall_flag, 0);
    chk("rst rsp_rdata", rsp_rdata, 0);
    rst_n = 1'b1;
    chk("cmd_ready pre-edge", cmd_ready, 0);
    @(posedge clk);
    #1;
    chk("cmd_ready first edge", cmd_ready, 1);
    @(negedge clk);

    // Zero-wait write, wait-state read, write skew, error with backpressure
    run_txn(1'b1, 32'h4, 32'h3, 4'hF, 0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF);
    run_txn(1'b0, 32'h8, 32'h0, 4'h0, 4, 0, 2, 0, 2'b00, 32'h1);
    run_txn(1'b1, 32'h10, 32'hCAFE_0001, 4'h3, 4, 0, 0, 0, 2'b00, 32'h0);
    run_txn(1'b0, 32'h20, 32'h0, 4'h0, 0, 0, 0, 10, 2'b10, 32'h1234_5678);

    // Randomized traffic
    for (int i = 0; i < 24; i++) begin
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom),
              $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 3), 2'($urandom), $urandom);
    end

    // Stall: BVALID never comes
    while (!cmd_ready) @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h40; cmd_wdata = 32'h55; cmd_wstrb = 4'hF;
    @(posedge clk);
    #1;
    cmd_valid = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      awready = (c == 1);
      wready  = (c == 1);
      bvalid  = 1'b0;
      if (c == 9)  chk("stall_flag at 7 wresp cycles", stall_flag, 0);
      if (c == 10) begin
        chk("stall_flag after 8 wresp cycles", stall_flag, 1);
        chk("bready while stalled", bready, 1);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst bready", bready, 0);
    chk("midrst stall_flag", stall_flag, 0);
    chk("midrst cmd_ready", cmd_ready, 0);
    chk("midrst rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("post-rst cmd_ready pre-edge", cmd_ready, 0);
    @(posedge clk);
    #1;
    chk("post-rst cmd_ready first edge", cmd_ready, 1);
    run_txn(1'b0, 32'h44, 32'h0, 4'h0, 1, 0, 1, 1, 2'b11, 32'hA5A5_5A5A);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
